out_port_sched: RTL and testbench

//  Per-output-port scheduler for the mesh router switch-allocation stage. Picks one of N_REQ input

---
 rtl/noc_pkg.sv | 12 +
 rtl/rr_arb_pick.sv | 23 ++
 rtl/out_port_sched.sv | 99 +++++++++
 tb/tb_out_port_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit encoding, field offsets and scheduler state type shared by the router.
package noc_pkg;
    localparam int DATASIZE_DEF = 40;
    localparam int TYPE_LSB = 0;
    localparam int DST_LSB = 32;
    localparam int SRC_LSB = 36;
    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_TAIL = 2'b01;
    localparam logic [1:0] FLIT_HEAD = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational rotate-priority pick; the search starts just after ptr.
module rr_arb_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = W'((int'(ptr) + i) % N);
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/out_port_sched.sv
// out_port_sched: per-output-port wormhole scheduler with round-robin pick, packet lock,
// downstream credit gating and a registered link output.
module out_port_sched import noc_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATASIZE-1:0] req_data,
    input  logic                      credit_in,
    output logic [N_REQ-1:0]          grant,
    output logic                      out_valid,
    output logic [DATASIZE-1:0]       out_data,
    output logic [WIDTH:0]            credits,
    output logic                      locked,
    output logic                      err
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [WIDTH:0] MAX_CR = (WIDTH + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [WIDTH:0]      credits_q, credits_d;
    logic                out_valid_q, out_valid_d, err_q, err_d;
    logic [DATASIZE-1:0] out_data_q, out_data_d, sel_flit;
    logic [N_REQ-1:0]    pick_gnt;
    logic [IW-1:0]       pick_idx, sel_idx;
    logic                pick_any, fire;
    logic [1:0]          ftype;

    rr_arb_pick #(.N(N_REQ), .W(IW)) u_pick (
        .req(req),
        .ptr(rr_ptr_q),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    always_comb begin
        sel_idx = state_q == LOCKED ? owner_q : pick_idx;
        fire = !rst && credits_q != '0 && (state_q == LOCKED ? req[owner_q] : pick_any);
        grant = fire ? (N_REQ'(1) << sel_idx) : '0;
        sel_flit = req_data[int'(sel_idx) * DATASIZE +: DATASIZE];
        ftype = sel_flit[TYPE_LSB +: 2];
        state_d = state_q;
        owner_d = owner_q;
        rr_ptr_d = rr_ptr_q;
        err_d = err_q;
        if (fire && state_q == IDLE) begin
            rr_ptr_d = sel_idx;
            state_d = ftype == FLIT_HEAD ? LOCKED : IDLE;
            owner_d = ftype == FLIT_HEAD ? sel_idx : owner_q;
            err_d = err_q | !ftype[1];
        end else if (fire) begin
            state_d = ftype == FLIT_TAIL ? IDLE : LOCKED;
            err_d = err_q | ftype[1];
        end
        // Orphan BODY/TAIL in IDLE leaves the port relabelled as SINGLE so downstream stays consistent.
        out_data_d = !fire ? out_data_q :
                     {sel_flit[DATASIZE-1:2], (state_q == IDLE && !ftype[1]) ? FLIT_SINGLE : ftype};
        out_valid_d = fire;
        credits_d = credits_q;
        if (fire && !credit_in)
            credits_d = credits_q - 1'b1;
        else if (credit_in && !fire && credits_q == MAX_CR)
            err_d = 1'b1;
        else if (credit_in && !fire)
            credits_d = credits_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_ptr_q <= IW'(N_REQ - 1);
            credits_q <= MAX_CR;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            credits_q <= credits_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            err_q <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign credits = credits_q;
    assign locked = state_q == LOCKED;
    assign err = err_q;
endmodule

// File: tb/tb_out_port_sched.sv
// tb_out_port_sched: directed vector table for reset, round-robin, lock and credit
// behaviour, plus hand-written credit-stall and mid-packet-reset sequences.
module tb_out_port_sched;
    logic         clk, rst, credit_in;
    logic [3:0]   req, grant;
    logic [159:0] req_data;
    logic         out_valid, locked, err;
    logic [39:0]  out_data;
    logic [3:0]   credits;
    logic [7:0]   ty;
    int           n_chk, n_fail, ng;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] ty;
        logic       cin;
        logic [3:0] eg;
        logic       eov;
        logic [3:0] ecr;
        logic       elk;
        logic       eerr;
        logic [3:0] esrc;
    } vec_t;
    vec_t vecs[$];

    out_port_sched dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .credit_in(credit_in),
        .grant(grant), .out_valid(out_valid), .out_data(out_data), .credits(credits),
        .locked(locked), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always_comb
        for (int i = 0; i < 4; i++)
            req_data[i*40 +: 40] = {4'(i), 4'd0, 8'(i + 16), 22'(i * 3 + 1), ty[i*2 +: 2]};

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] t, input logic c,
                       input logic [3:0] eg, input logic eov, input logic [3:0] ecr,
                       input logic elk, input logic eerr, input logic [3:0] esrc);
        vec_t v;
        v.rst = r; v.req = rq; v.ty = t; v.cin = c; v.eg = eg; v.eov = eov;
        v.ecr = ecr; v.elk = elk; v.eerr = eerr; v.esrc = esrc;
        vecs.push_back(v);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; ng = 0;
        rst = 1'b1; req = 4'b0; credit_in = 1'b0; ty = 8'hFF;
        @(posedge clk);
        add(1, 4'hF, 8'hFF, 0, 4'h0, 0, 8, 0, 0, 0);
        add(1, 4'hF, 8'hFF, 0, 4'h0, 0, 8, 0, 0, 0);
        add(0, 4'hF, 8'hFF, 1, 4'h1, 0, 8, 0, 0, 0);
        add(0, 4'hF, 8'hFF, 1, 4'h2, 1, 8, 0, 0, 0);
        add(0, 4'hF, 8'hFF, 1, 4'h4, 1, 8, 0, 0, 1);
        add(0, 4'hF, 8'hFF, 1, 4'h8, 1, 8, 0, 0, 2);
        add(0, 4'hF, 8'hFF, 1, 4'h1, 1, 8, 0, 0, 3);
        add(0, 4'h8, 8'hFF, 1, 4'h8, 1, 8, 0, 0, 0);
        add(0, 4'h3, 8'hFE, 0, 4'h1, 1, 8, 0, 0, 3);
        add(0, 4'h3, 8'hFC, 0, 4'h1, 1, 7, 1, 0, 0);
        add(0, 4'h3, 8'hFC, 0, 4'h1, 1, 6, 1, 0, 0);
        add(0, 4'h3, 8'hFD, 0, 4'h1, 1, 5, 1, 0, 0);
        add(0, 4'h2, 8'hFF, 0, 4'h2, 1, 4, 0, 0, 0);
        add(0, 4'h2, 8'hFF, 1, 4'h2, 1, 3, 0, 0, 1);
        add(0, 4'h0, 8'hFF, 0, 4'h0, 1, 3, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            add(0, 4'h0, 8'hFF, 1, 4'h0, 0, 4'(3 + k), 0, 0, 0);
        add(0, 4'h0, 8'hFF, 1, 4'h0, 0, 8, 0, 0, 0);
        add(0, 4'h0, 8'hFF, 0, 4'h0, 0, 8, 0, 1, 0);
        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; req = vecs[k].req; ty = vecs[k].ty; credit_in = vecs[k].cin;
            #1;
            chk($sformatf("v%0d_grant", k), 40'(grant), 40'(vecs[k].eg));
            chk($sformatf("v%0d_out_valid", k), 40'(out_valid), 40'(vecs[k].eov));
            chk($sformatf("v%0d_credits", k), 40'(credits), 40'(vecs[k].ecr));
            chk($sformatf("v%0d_locked", k), 40'(locked), 40'(vecs[k].elk));
            chk($sformatf("v%0d_err", k), 40'(err), 40'(vecs[k].eerr));
            if (vecs[k].eov)
                chk($sformatf("v%0d_src", k), 40'(out_data[39:36]), 40'(vecs[k].esrc));
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req = 4'b0001; ty = 8'hFF; credit_in = 1'b0;
            #1;
            if (grant == 4'b0001) ng++;
        end
        chk("t4_grant_count", 40'(ng), 40'd8);
        @(negedge clk);
        credit_in = 1'b1;
        #1;
        chk("t4_credits_zero", 40'(credits), 40'd0);
        chk("t4_stall_grant", 40'(grant), 40'd0);
        @(negedge clk);
        credit_in = 1'b0;
        #1;
        chk("t4_credit_back", 40'(credits), 40'd1);
        chk("t4_regrant", 40'(grant), 40'h1);
        @(negedge clk);
        req = 4'b0;
        #1;
        chk("t4_credits_drained", 40'(credits), 40'd0);
        chk("t4_out_valid", 40'(out_valid), 40'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 4'b0100; ty = 8'hEF;
        #1;
        chk("t6_head_grant", 40'(grant), 40'h4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_locked_before_rst", 40'(locked), 40'd1);
        chk("t6_grant_in_rst", 40'(grant), 40'd0);
        @(negedge clk);
        rst = 1'b0; req = 4'b0110; ty = 8'hCF;
        #1;
        chk("t6_locked_dropped", 40'(locked), 40'd0);
        chk("t6_err_cleared", 40'(err), 40'd0);
        chk("t6_credits_reset", 40'(credits), 40'd8);
        chk("t6_req1_first", 40'(grant), 40'h2);
        @(negedge clk);
        req = 4'b0100;
        #1;
        chk("t6_body_grant", 40'(grant), 40'h4);
        chk("t6_req1_src", 40'(out_data[39:36]), 40'd1);
        @(negedge clk);
        req = 4'b0;
        #1;
        chk("t6_body_err", 40'(err), 40'd1);
        chk("t6_still_idle", 40'(locked), 40'd0);
        chk("t6_body_src", 40'(out_data[39:36]), 40'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
